// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game-state engine.
//   - grid geometry and coordinate width
//   - direction / state encodings and the reversal test
//   - reset snake head/length and the default apple placement table
//   - LFSR width, seed and feedback taps
package snake_pkg;

  localparam int COORD_W = 6;
  localparam int GRID_W  = 64;
  localparam int GRID_H  = 48;
  localparam int LEN_W   = 7;
  localparam int SCORE_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  localparam int                RST_HEAD_X = 32;
  localparam int                RST_HEAD_Y = 24;
  localparam logic [LEN_W-1:0]  RST_LEN    = 7'd3;

  // Apple k lives at bits [6k+5:6k]; apple 0 is the rightmost field.
  localparam logic [5*COORD_W-1:0] APPLE_RST_X = {6'd40, 6'd50, 6'd10, 6'd50, 6'd10};
  localparam logic [5*COORD_W-1:0] APPLE_RST_Y = {6'd30, 6'd40, 6'd40, 6'd10, 6'd10};

  localparam int               LFSR_W    = 12;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 12'hACE;
  // Taps 12,11,10,4 (1-based) -> bits 11,10,9,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'hE08;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return b == {a[1], ~a[0]};
  endfunction

  // Reset x of body entry i: a straight 3-cell snake, unused entries sit on the tail.
  function automatic coord_t rst_seg_x(input int i);
    if (i < int'(RST_LEN))
      return coord_t'(RST_HEAD_X - i);
    return coord_t'(RST_HEAD_X - int'(RST_LEN) + 1);
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// snake_lfsr: free-running 12-bit Fibonacci LFSR that proposes apple cells.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (loads the seed)
//   rand_x_o  out  lfsr[5:0]
//   rand_y_o  out  lfsr[11:6], folded into 0..47
module snake_lfsr
  import snake_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  output coord_t rand_x_o,
  output coord_t rand_y_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  coord_t            y_raw;

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign y_raw    = lfsr_q[2*COORD_W-1:COORD_W];
  assign rand_x_o = lfsr_q[COORD_W-1:0];
  // Rows 48..63 do not exist; shifting them down by 16 keeps every value on-grid.
  assign rand_y_o = (y_raw >= coord_t'(GRID_H)) ? y_raw - coord_t'(2**COORD_W - GRID_H) : y_raw;

endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake game state for the VGA renderer.
//   clk, rst_n         clock, asynchronous active-low reset
//   tick               one move per strobe while running
//   dir_in, dir_valid  requested heading (0 UP,1 DOWN,2 LEFT,3 RIGHT)
//   snake_x/snake_y    packed body, segment 0 = head
//   apple_x/apple_y    packed apple cells
//   snake_len, score   active length, saturating apple count
//   game_over          high once dead, until reset
module snake_engine
  import snake_pkg::*;
#(
  parameter int                          MAX_LEN      = 100,
  parameter int                          APPLES       = 5,
  parameter logic [COORD_W*APPLES-1:0]   APPLE_INIT_X = APPLE_RST_X,
  parameter logic [COORD_W*APPLES-1:0]   APPLE_INIT_Y = APPLE_RST_Y
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [1:0]                   dir_in,
  input  logic                         dir_valid,
  output logic [COORD_W*MAX_LEN-1:0]   snake_x,
  output logic [COORD_W*MAX_LEN-1:0]   snake_y,
  output logic [COORD_W*APPLES-1:0]    apple_x,
  output logic [COORD_W*APPLES-1:0]    apple_y,
  output logic [LEN_W-1:0]             snake_len,
  output logic [SCORE_W-1:0]           score,
  output logic                         game_over
);

  localparam int IDX_W = (APPLES > 1) ? $clog2(APPLES) : 1;

  coord_t             seg_x_q [MAX_LEN];
  coord_t             seg_y_q [MAX_LEN];
  coord_t             apple_x_q [APPLES];
  coord_t             apple_y_q [APPLES];
  state_e             state_q;
  dir_e               dir_q, last_dir_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SCORE_W-1:0] score_q;
  logic               game_over_q;

  coord_t             rand_x, rand_y;
  coord_t             nh_x, nh_y, tail_x, tail_y;
  logic               hit_wall, hit_self, eat, move, do_shift, die, accept;
  logic [APPLES-1:0]  apple_hit;
  logic [MAX_LEN-1:0] seg_hit;
  logic [IDX_W-1:0]   eat_idx;

  snake_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_x_o (rand_x),
    .rand_y_o (rand_y)
  );

  assign move = (state_q == ST_RUN) && tick;

  // Candidate head and wall test for the current heading.
  always_comb begin
    nh_x     = seg_x_q[0];
    nh_y     = seg_y_q[0];
    hit_wall = 1'b0;
    case (dir_q)
      DIR_UP:    begin hit_wall = (seg_y_q[0] == '0);                 nh_y = seg_y_q[0] - 1'b1; end
      DIR_DOWN:  begin hit_wall = (seg_y_q[0] == coord_t'(GRID_H-1)); nh_y = seg_y_q[0] + 1'b1; end
      DIR_LEFT:  begin hit_wall = (seg_x_q[0] == '0);                 nh_x = seg_x_q[0] - 1'b1; end
      DIR_RIGHT: begin hit_wall = (seg_x_q[0] == coord_t'(GRID_W-1)); nh_x = seg_x_q[0] + 1'b1; end
      default:   ;
    endcase
  end

  for (genvar gi = 0; gi < APPLES; gi++) begin : g_apple_hit
    assign apple_hit[gi] = (apple_x_q[gi] == nh_x) && (apple_y_q[gi] == nh_y);
  end
  assign eat = |apple_hit;

  // Lowest-numbered matching apple wins.
  always_comb begin
    eat_idx = '0;
    for (int k = APPLES - 1; k >= 0; k--)
      if (apple_hit[k]) eat_idx = IDX_W'(k);
  end

  // The tail cell is vacated by the move unless the snake eats, so it only
  // counts as an obstacle when eating.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg_hit
    assign seg_hit[gi] = (seg_x_q[gi] == nh_x) && (seg_y_q[gi] == nh_y) &&
                         (eat ? (LEN_W'(gi) < len_q) : (LEN_W'(gi + 1) < len_q));
  end
  assign hit_self = |seg_hit;

  assign do_shift = move && !hit_wall && !hit_self;
  assign die      = move && (hit_wall || hit_self);
  assign len_d    = (do_shift && eat && (len_q < LEN_W'(MAX_LEN))) ? len_q + 1'b1 : len_q;

  // Entries at or past the new length copy the new tail so idle slots draw on it.
  assign tail_x = seg_x_q[len_d - LEN_W'(2)];
  assign tail_y = seg_y_q[len_d - LEN_W'(2)];

  // On a move cycle the heading being used now becomes the last-move heading.
  assign accept = dir_valid && (state_q != ST_DEAD) &&
                  !is_reverse(dir_in, move ? dir_q : last_dir_q);

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_body
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_x_q[gi] <= rst_seg_x(gi);
          seg_y_q[gi] <= coord_t'(RST_HEAD_Y);
        end else if (do_shift) begin
          seg_x_q[gi] <= nh_x;
          seg_y_q[gi] <= nh_y;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_x_q[gi] <= rst_seg_x(gi);
          seg_y_q[gi] <= coord_t'(RST_HEAD_Y);
        end else if (do_shift) begin
          seg_x_q[gi] <= (LEN_W'(gi) < len_d) ? seg_x_q[gi-1] : tail_x;
          seg_y_q[gi] <= (LEN_W'(gi) < len_d) ? seg_y_q[gi-1] : tail_y;
        end
      end
    end
    assign snake_x[COORD_W*gi +: COORD_W] = seg_x_q[gi];
    assign snake_y[COORD_W*gi +: COORD_W] = seg_y_q[gi];
  end

  for (genvar gi = 0; gi < APPLES; gi++) begin : g_apple
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        apple_x_q[gi] <= APPLE_INIT_X[COORD_W*gi +: COORD_W];
        apple_y_q[gi] <= APPLE_INIT_Y[COORD_W*gi +: COORD_W];
      end else if (do_shift && eat && (eat_idx == IDX_W'(gi))) begin
        apple_x_q[gi] <= rand_x;
        apple_y_q[gi] <= rand_y;
      end
    end
    assign apple_x[COORD_W*gi +: COORD_W] = apple_x_q[gi];
    assign apple_y[COORD_W*gi +: COORD_W] = apple_y_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      last_dir_q  <= DIR_RIGHT;
      len_q       <= RST_LEN;
      score_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            dir_q   <= dir_e'(dir_in);
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) dir_q <= dir_e'(dir_in);
          if (move)   last_dir_q <= dir_q;
          if (die) begin
            state_q     <= ST_DEAD;
            game_over_q <= 1'b1;
          end
          if (do_shift) begin
            len_q <= len_d;
            if (eat && (score_q != '1)) score_q <= score_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign snake_len = len_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;

  localparam logic [29:0] AX_INIT = {6'd34, 6'd35, 6'd10, 6'd50, 6'd10};
  localparam logic [29:0] AY_INIT = {6'd24, 6'd24, 6'd40, 6'd10, 6'd10};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         dir_valid = 1'b0;
  logic [1:0]   dir_in = 2'd0;
  logic [599:0] snake_x, snake_y;
  logic [29:0]  apple_x, apple_y;
  logic [6:0]   snake_len;
  logic [9:0]   score;
  logic         game_over;

  snake_engine #(
    .MAX_LEN      (100),
    .APPLES       (5),
    .APPLE_INIT_X (AX_INIT),
    .APPLE_INIT_Y (AY_INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .snake_x   (snake_x),
    .snake_y   (snake_y),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .snake_len (snake_len),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: body as a queue of cells (head first), game rules in plain arithmetic.
  int bx[$];
  int by[$];
  int ax[5];
  int ay[5];
  int m_dir, m_last, m_state, m_score, m_lfsr;   // m_state: 0 idle, 1 run, 2 dead

  task automatic check_eq(input string tag, input logic [599:0] got, input logic [599:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    bx = '{32, 31, 30};
    by = '{24, 24, 24};
    ax = '{10, 50, 10, 35, 34};
    ay = '{10, 10, 40, 24, 24};
    m_dir = 3; m_last = 3; m_state = 0; m_score = 0;
    m_lfsr = 'hACE;
  endtask

  task automatic model_step(input bit t, input bit dv, input int d);
    int nx, ny, k, lim, newdir, ry, fb;
    bit moving, accept, hit;
    moving = (m_state == 1) && t;
    accept = dv && (m_state != 2) && (d != opposite(moving ? m_dir : m_last));
    newdir = accept ? d : m_dir;
    if (m_state == 0) begin
      if (accept) m_state = 1;
    end else if (moving) begin
      nx = bx[0]; ny = by[0];
      case (m_dir)
        0: ny = ny - 1;
        1: ny = ny + 1;
        2: nx = nx - 1;
        default: nx = nx + 1;
      endcase
      m_last = m_dir;
      if (nx < 0 || nx > 63 || ny < 0 || ny > 47) begin
        m_state = 2;
      end else begin
        k = -1;
        for (int a = 4; a >= 0; a--)
          if (ax[a] == nx && ay[a] == ny) k = a;
        lim = (k >= 0) ? bx.size() - 1 : bx.size() - 2;
        hit = 0;
        for (int j = 0; j <= lim; j++)
          if (bx[j] == nx && by[j] == ny) hit = 1;
        if (hit) begin
          m_state = 2;
        end else begin
          bx.push_front(nx);
          by.push_front(ny);
          if (!(k >= 0 && bx.size() <= 100)) begin
            void'(bx.pop_back());
            void'(by.pop_back());
          end
          if (k >= 0) begin
            if (m_score < 1023) m_score++;
            ax[k] = m_lfsr % 64;
            ry = (m_lfsr / 64) % 64;
            ay[k] = (ry >= 48) ? ry - 16 : ry;
          end
        end
      end
    end
    m_dir = newdir;
    fb = ((m_lfsr >> 11) ^ (m_lfsr >> 10) ^ (m_lfsr >> 9) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr * 2) + fb) % 4096;
  endtask

  function automatic logic [599:0] model_body(input bit use_y);
    logic [599:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < 100; i++) begin
      idx = (i < bx.size()) ? i : bx.size() - 1;
      v[6*i +: 6] = use_y ? 6'(by[idx]) : 6'(bx[idx]);
    end
    return v;
  endfunction

  function automatic logic [29:0] model_apples(input bit use_y);
    logic [29:0] v;
    for (int k = 0; k < 5; k++)
      v[6*k +: 6] = use_y ? 6'(ay[k]) : 6'(ax[k]);
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".snake_x"},   snake_x,   model_body(0));
    check_eq({tag, ".snake_y"},   snake_y,   model_body(1));
    check_eq({tag, ".apple_x"},   apple_x,   model_apples(0));
    check_eq({tag, ".apple_y"},   apple_y,   model_apples(1));
    check_eq({tag, ".snake_len"}, snake_len, bx.size());
    check_eq({tag, ".score"},     score,     m_score);
    check_eq({tag, ".game_over"}, game_over, (m_state == 2));
  endtask

  // One clock: drive inputs in the low phase, let the edge happen, check #1 later.
  task automatic cyc(input string tag, input bit t, input bit dv, input logic [1:0] d);
    tick = t; dir_valid = dv; dir_in = d;
    @(posedge clk);
    model_step(t, dv, int'(d));
    #1;
    compare_all(tag);
    @(negedge clk);
    tick = 1'b0; dir_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Reset pulled low inside a tick cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    tick = 1'b1; dir_valid = 1'b1; dir_in = 2'($urandom_range(0, 3));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk);
    tick = 1'b0; dir_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int dead_cnt;
    bit t, dv;
    @(negedge clk);
    do_reset();
    compare_all("reset");
    check_eq("reset.head_x", snake_x[5:0], 32);
    check_eq("reset.head_y", snake_y[5:0], 24);
    check_eq("reset.e99_x", snake_x[599:594], 30);
    check_eq("reset.len", snake_len, 3);
    check_eq("reset.apples_x", apple_x, AX_INIT);
    check_eq("reset.apples_y", apple_y, AY_INIT);
    check_eq("reset.game_over", game_over, 0);

    cyc("idle_tick", 1, 0, 2'd0);
    check_eq("idle_tick.head_x", snake_x[5:0], 32);

    cyc("start_right", 0, 1, 2'd3);
    cyc("move1", 1, 0, 2'd0);
    check_eq("move1.seg0_x", snake_x[5:0], 33);
    check_eq("move1.seg1_x", snake_x[11:6], 32);
    check_eq("move1.seg2_x", snake_x[17:12], 31);
    check_eq("move1.e99_x", snake_x[599:594], 31);
    check_eq("move1.len", snake_len, 3);

    cyc("reverse_req", 0, 1, 2'd2);
    cyc("eat4", 1, 0, 2'd0);
    check_eq("eat4.head_x", snake_x[5:0], 34);
    check_eq("eat4.len", snake_len, 4);
    check_eq("eat4.score", score, 1);
    check_eq("eat4.tail_x", snake_x[23:18], 31);
    check_eq("eat4.apple4_y_ok", apple_y[29:24] < 6'd48, 1);

    cyc("eat3", 1, 0, 2'd0);
    check_eq("eat3.len", snake_len, 5);
    cyc("turn_down", 0, 1, 2'd1);
    cyc("mv_down", 1, 0, 2'd0);
    cyc("turn_left", 0, 1, 2'd2);
    cyc("mv_left", 1, 0, 2'd0);
    cyc("turn_up", 0, 1, 2'd0);
    cyc("self_hit", 1, 0, 2'd0);
    check_eq("self_hit.game_over", game_over, 1);
    check_eq("self_hit.head_x", snake_x[5:0], 34);
    check_eq("self_hit.head_y", snake_y[5:0], 25);

    for (int c = 0; c < 12; c++)
      cyc("dead_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    mid_reset("mid_reset_dead");

    // Straight run into the right wall.
    do_reset();
    cyc("wall_start", 0, 1, 2'd3);
    for (int c = 0; c < 31; c++) cyc("wall_run", 1, 0, 2'd0);
    check_eq("wall_run.head_x", snake_x[5:0], 63);
    cyc("wall_hit", 1, 0, 2'd0);
    check_eq("wall_hit.game_over", game_over, 1);
    check_eq("wall_hit.head_x", snake_x[5:0], 63);
    cyc("wall_dead", 1, 1, 2'd0);

    // Random play, including ticks and direction requests on the same cycle.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      compare_all("rand_reset");
      dead_cnt = 0;
      for (int c = 0; c < 400; c++) begin
        t  = ($urandom_range(0, 1) == 1);
        dv = ($urandom_range(0, 2) == 0);
        cyc("rand", t, dv, 2'($urandom_range(0, 3)));
        if (ep == 4 && c == 60) mid_reset("mid_reset_run");
        if (m_state == 2) dead_cnt++;
        if (dead_cnt > 5) break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
